// File: rtl/spatz_issue_controller_if.sv
// Request types and the decoder/unit-facing bundle of the Spatz issue controller.
// Signal names keep the legacy port names so existing hookups map one-to-one.
package spatz_issue_pkg;
  typedef logic [3:0] instr_id_t;
  typedef logic [4:0] vreg_t;
  typedef enum logic [1:0] {CON = 2'd0, LSU = 2'd1, SLD = 2'd2, VFU = 2'd3} ex_unit_e;

  typedef struct packed {
    instr_id_t id;
    ex_unit_e  ex_unit;
    logic [7:0] op;
    vreg_t     vd;
    logic      use_vd;
    vreg_t     vs1;
    logic      use_vs1;
    vreg_t     vs2;
    logic      use_vs2;
    logic      vd_is_src;
  } spatz_req_t;
endpackage

interface spatz_issue_controller_if;
  import spatz_issue_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  spatz_req_t      req_i;
  spatz_req_t      issue_req_o;
  logic            con_valid_o;
  logic            con_ready_i;
  logic            lsu_valid_o;
  logic            lsu_ready_i;
  logic            sld_valid_o;
  logic            sld_ready_i;
  logic            vfu_valid_o;
  logic            vfu_ready_i;
  logic [3:0]      done_valid_i;
  instr_id_t [3:0] done_id_i;
  logic            idle_o;

  modport slave (
    input  req_valid_i, req_i, con_ready_i, lsu_ready_i, sld_ready_i, vfu_ready_i,
           done_valid_i, done_id_i,
    output req_ready_o, issue_req_o, con_valid_o, lsu_valid_o, sld_valid_o, vfu_valid_o,
           idle_o
  );

  modport master (
    output req_valid_i, req_i, con_ready_i, lsu_ready_i, sld_ready_i, vfu_ready_i,
           done_valid_i, done_id_i,
    input  req_ready_o, issue_req_o, con_valid_o, lsu_valid_o, sld_valid_o, vfu_valid_o,
           idle_o
  );
endinterface

// File: rtl/spatz_issue_controller.sv
// Spatz issue stage: ID allocation, vector-register hazard blocking, registered
// dispatch to CON/LSU/SLD/VFU and per-unit retirement.
module spatz_issue_controller
  import spatz_issue_pkg::*;
#(
  parameter int unsigned NrIds = 16  // must equal 2**$bits(instr_id_t)
) (
  input logic                     clk_i,
  input logic                     rst_i,
  spatz_issue_controller_if.slave bus
);
  localparam int unsigned IdW = $bits(instr_id_t);

  typedef struct packed {
    vreg_t vd;
    logic  use_vd;
    vreg_t vs1;
    logic  use_vs1;
    vreg_t vs2;
    logic  use_vs2;
    logic  is_con;
  } entry_t;

  logic [NrIds-1:0] r_valid;
  entry_t           r_tbl [NrIds];
  logic             r_out_valid;
  spatz_req_t       r_out_req;

  spatz_req_t       w_req;
  spatz_req_t       w_out_req;
  entry_t           w_new;
  instr_id_t        w_alloc_id;
  logic             w_free;
  logic             w_hazard;
  logic             w_con_inflight;
  logic             w_idle;
  logic             w_drain_ok;
  logic             w_sel_ready;
  logic             w_fire;
  logic             w_accept;
  logic [NrIds-1:0] w_clr;
  logic [NrIds-1:0] w_set;

  assign w_req  = bus.req_i;
  assign w_idle = ~|r_valid & ~r_out_valid;

  // Hazards and the CON drain check look only at the registered table.
  always_comb begin
    w_hazard       = 1'b0;
    w_con_inflight = 1'b0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      if (r_valid[i]) begin
        w_con_inflight = w_con_inflight | r_tbl[i].is_con;
        w_hazard = w_hazard
          | (r_tbl[i].use_vd & w_req.use_vs1 & (w_req.vs1 == r_tbl[i].vd))
          | (r_tbl[i].use_vd & w_req.use_vs2 & (w_req.vs2 == r_tbl[i].vd))
          | (r_tbl[i].use_vd & w_req.use_vd & (w_req.vd == r_tbl[i].vd))
          | (w_req.use_vd & r_tbl[i].use_vs1 & (w_req.vd == r_tbl[i].vs1))
          | (w_req.use_vd & r_tbl[i].use_vs2 & (w_req.vd == r_tbl[i].vs2));
      end
    end
  end

  always_comb begin
    w_free     = 1'b0;
    w_alloc_id = '0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      if (!r_valid[i] && !w_free) begin
        w_free     = 1'b1;
        w_alloc_id = IdW'(i);
      end
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    unique case (r_out_req.ex_unit)
      CON:     w_sel_ready = bus.con_ready_i;
      LSU:     w_sel_ready = bus.lsu_ready_i;
      SLD:     w_sel_ready = bus.sld_ready_i;
      VFU:     w_sel_ready = bus.vfu_ready_i;
      default: w_sel_ready = 1'b0;
    endcase
  end

  assign w_fire     = r_out_valid & w_sel_ready;
  assign w_drain_ok = ~w_con_inflight & ((w_req.ex_unit != CON) | w_idle);
  assign w_accept   = ~rst_i & bus.req_valid_i & w_free & ~w_hazard & w_drain_ok
                    & (~r_out_valid | w_fire);

  always_comb begin
    w_clr = '0;
    for (int unsigned u = 0; u < 4; u++) begin
      if (bus.done_valid_i[u]) w_clr[bus.done_id_i[u]] = 1'b1;
    end
    w_set = '0;
    if (w_accept) w_set[w_alloc_id] = 1'b1;
  end

  always_comb begin
    w_out_req    = w_req;
    w_out_req.id = w_alloc_id;
    w_new        = '{vd: w_req.vd, use_vd: w_req.use_vd, vs1: w_req.vs1,
                     use_vs1: w_req.use_vs1, vs2: w_req.vs2, use_vs2: w_req.use_vs2,
                     is_con: (w_req.ex_unit == CON)};
  end

  // The allocated slot is free pre-retire, so set-after-clear cannot collide
  // with a genuine retire; a stale retire to that slot loses to the allocation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_out_valid <= 1'b0;
      r_out_req   <= '0;
    end else begin
      r_valid <= (r_valid & ~w_clr) | w_set;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_req   <= w_out_req;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_tbl[w_alloc_id] <= w_new;
  end

  assign bus.req_ready_o = w_accept;
  assign bus.issue_req_o = r_out_req;
  assign bus.con_valid_o = r_out_valid & (r_out_req.ex_unit == CON);
  assign bus.lsu_valid_o = r_out_valid & (r_out_req.ex_unit == LSU);
  assign bus.sld_valid_o = r_out_valid & (r_out_req.ex_unit == SLD);
  assign bus.vfu_valid_o = r_out_valid & (r_out_req.ex_unit == VFU);
  assign bus.idle_o      = w_idle;
endmodule

// File: tb/tb_spatz_issue_controller.sv
// Bench for spatz_issue_controller: directed scenarios plus a random phase, all
// checked each cycle against a set-of-in-flight-requests reference model.
module tb_spatz_issue_controller;
  import spatz_issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spatz_issue_controller_if bus ();
  spatz_issue_controller #(.NrIds(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Reference model: which IDs are in flight, what they carry, and the pending dispatch.
  bit         m_busy [16];
  spatz_req_t m_req  [16];
  bit         m_out_v;
  spatz_req_t m_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_acc;
  int last_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic spatz_req_t mk(input ex_unit_e u, input int vd, input int vs1, input int vs2,
                                    input bit uvd, input bit uvs1, input bit uvs2, input bit src);
    spatz_req_t r;
    r.id = instr_id_t'($urandom);
    r.ex_unit = u;
    r.op = 8'($urandom);
    r.vd = vreg_t'(vd);
    r.use_vd = uvd;
    r.vs1 = vreg_t'(vs1);
    r.use_vs1 = uvs1;
    r.vs2 = vreg_t'(vs2);
    r.use_vs2 = uvs2;
    r.vd_is_src = src;
    return r;
  endfunction

  function automatic bit hz(input spatz_req_t n, input spatz_req_t e);
    bit raw, waw, war;
    raw = (n.use_vs1 && n.vs1 == e.vd && e.use_vd) || (n.use_vs2 && n.vs2 == e.vd && e.use_vd)
       || (n.vd_is_src && n.use_vd && n.vd == e.vd && e.use_vd);
    waw = n.use_vd && e.use_vd && n.vd == e.vd;
    war = n.use_vd && ((e.use_vs1 && n.vd == e.vs1) || (e.use_vs2 && n.vd == e.vs2));
    return raw || waw || war;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < 16; i++) if (m_busy[i]) return 1'b0;
    return !m_out_v;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit ready_of(input ex_unit_e u);
    case (u)
      CON: return bus.con_ready_i;
      LSU: return bus.lsu_ready_i;
      SLD: return bus.sld_ready_i;
      default: return bus.vfu_ready_i;
    endcase
  endfunction

  task automatic mreset();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_out_v = 1'b0;
  endtask

  // One clock cycle: predict and check outputs mid-cycle, then advance the model.
  task automatic tick();
    bit fire, rdy, any_con, haz;
    int a;
    logic [3:0] vexp;
    #3;
    fire = m_out_v && ready_of(m_out.ex_unit);
    a = lowest_free();
    any_con = 1'b0;
    haz = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i]) begin
        any_con = any_con | (m_req[i].ex_unit == CON);
        haz = haz | hz(bus.req_i, m_req[i]);
      end
    end
    rdy = bus.req_valid_i && (a >= 0) && !haz && !any_con
       && (bus.req_i.ex_unit != CON || model_idle()) && (!m_out_v || fire);
    chk("req_ready", 64'(bus.req_ready_o), 64'(rdy));
    vexp = m_out_v ? (4'b0001 << m_out.ex_unit) : 4'b0000;
    chk("unit_valid", 64'({bus.vfu_valid_o, bus.sld_valid_o, bus.lsu_valid_o, bus.con_valid_o}),
        64'(vexp));
    if (m_out_v) chk("issue_req", 64'(bus.issue_req_o), 64'(m_out));
    chk("idle", 64'(bus.idle_o), 64'(model_idle()));
    @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) if (bus.done_valid_i[u]) m_busy[bus.done_id_i[u]] = 1'b0;
    if (fire) m_out_v = 1'b0;
    if (rdy) begin
      m_busy[a] = 1'b1;
      m_req[a] = bus.req_i;
      m_out = bus.req_i;
      m_out.id = instr_id_t'(a);
      m_out_v = 1'b1;
    end
    last_acc = rdy;
    last_id = a;
    bus.done_valid_i = '0;
  endtask

  task automatic put(input spatz_req_t r);
    bus.req_i = r;
    bus.req_valid_i = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 40 && !last_acc; k++) tick();
    chk("put_accept", 64'(last_acc), 64'(1));
    bus.req_valid_i = 1'b0;
  endtask

  task automatic retire(input int u, input int id);
    bus.done_valid_i[u] = 1'b1;
    bus.done_id_i[u] = instr_id_t'(id);
    tick();
  endtask

  task automatic set_ready(input bit v);
    bus.con_ready_i = v;
    bus.lsu_ready_i = v;
    bus.sld_ready_i = v;
    bus.vfu_ready_i = v;
  endtask

  task automatic drain();
    int id;
    set_ready(1'b1);
    bus.req_valid_i = 1'b0;
    for (int k = 0; k < 80 && !model_idle(); k++) begin
      id = -1;
      for (int i = 0; i < 16; i++)
        if (id < 0 && m_busy[i] && !(m_out_v && m_out.id == i)) id = i;
      if (id >= 0) retire(int'(m_req[id].ex_unit), id);
      else tick();
    end
    chk("drain_idle", 64'(bus.idle_o), 64'(1));
  endtask

  task automatic stall(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(tag, 64'(last_acc), 64'(0));
    end
  endtask

  initial begin
    spatz_req_t saved;
    int q[$];
    int uu, pick;

    rst = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_i = mk(VFU, 1, 2, 3, 1, 1, 1, 0);
    bus.done_valid_i = '0;
    bus.done_id_i = '0;
    set_ready(1'b1);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rst_valids", 64'({bus.vfu_valid_o, bus.sld_valid_o, bus.lsu_valid_o, bus.con_valid_o}),
        64'(0));
    chk("rst_issue_req", 64'(bus.issue_req_o), 64'(0));
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("rst_idle", 64'(bus.idle_o), 64'(1));

    // Independent back-to-back VADDs
    bus.req_i = mk(VFU, 1, 2, 3, 1, 1, 1, 0);
    bus.req_valid_i = 1'b1;
    tick();
    chk("indep_acc0", 64'(last_acc), 64'(1));
    chk("indep_out0_id", 64'(bus.issue_req_o.id), 64'(0));
    chk("indep_out0_v", 64'(bus.vfu_valid_o), 64'(1));
    bus.req_i = mk(VFU, 4, 5, 6, 1, 1, 1, 0);
    tick();
    chk("indep_acc1", 64'(last_acc), 64'(1));
    chk("indep_out1_id", 64'(bus.issue_req_o.id), 64'(1));
    chk("indep_out1_v", 64'(bus.vfu_valid_o), 64'(1));
    drain();

    // RAW: VADD reads v2 written by an in-flight VLE
    put(mk(LSU, 2, 0, 0, 1, 0, 0, 0));
    chk("raw_vle_id", 64'(last_id), 64'(0));
    bus.req_i = mk(VFU, 9, 2, 3, 1, 1, 0, 0);
    bus.req_valid_i = 1'b1;
    stall("raw_stall", 3);
    retire(1, 0);
    chk("raw_stall_on_done", 64'(last_acc), 64'(0));
    tick();
    chk("raw_acc_after_done", 64'(last_acc), 64'(1));
    chk("raw_out_v", 64'(bus.vfu_valid_o), 64'(1));
    chk("raw_out_id", 64'(bus.issue_req_o.id), 64'(0));
    drain();

    // WAR: VLE writes v7 still read by an in-flight VADD
    put(mk(VFU, 8, 9, 7, 1, 1, 1, 0));
    bus.req_i = mk(LSU, 7, 0, 0, 1, 0, 0, 0);
    bus.req_valid_i = 1'b1;
    stall("war_stall", 4);
    retire(3, 0);
    chk("war_stall_on_done", 64'(last_acc), 64'(0));
    tick();
    chk("war_acc", 64'(last_acc), 64'(1));
    drain();

    // Full pool, then free id 5
    for (int i = 0; i < 16; i++) begin
      put(mk(VFU, i, 0, 0, 1, 0, 0, 0));
      chk("full_id", 64'(last_id), 64'(i));
    end
    bus.req_i = mk(VFU, 20, 0, 0, 1, 0, 0, 0);
    bus.req_valid_i = 1'b1;
    stall("full_stall", 3);
    retire(3, 5);
    chk("full_stall_on_done", 64'(last_acc), 64'(0));
    tick();
    chk("full_acc", 64'(last_acc), 64'(1));
    chk("full_reuse_id", 64'(last_id), 64'(5));
    drain();

    // VCFG waits for three ops, then blocks the next op
    for (int i = 1; i <= 3; i++) put(mk(VFU, i, 0, 0, 1, 0, 0, 0));
    bus.req_i = mk(CON, 0, 0, 0, 0, 0, 0, 0);
    bus.req_valid_i = 1'b1;
    stall("vcfg_wait", 2);
    retire(3, 0);
    retire(3, 1);
    chk("vcfg_wait2", 64'(last_acc), 64'(0));
    retire(3, 2);
    chk("vcfg_wait3", 64'(last_acc), 64'(0));
    tick();
    chk("vcfg_acc", 64'(last_acc), 64'(1));
    chk("vcfg_con_valid", 64'(bus.con_valid_o), 64'(1));
    bus.req_i = mk(VFU, 5, 0, 0, 1, 0, 0, 0);
    stall("vcfg_block_next", 3);
    retire(0, 0);
    chk("vcfg_block_on_done", 64'(last_acc), 64'(0));
    tick();
    chk("vcfg_next_acc", 64'(last_acc), 64'(1));
    drain();

    // Backpressure on the VFU
    bus.vfu_ready_i = 1'b0;
    put(mk(VFU, 1, 2, 3, 1, 1, 1, 0));
    saved = bus.issue_req_o;
    bus.req_i = mk(VFU, 10, 11, 12, 1, 1, 1, 0);
    bus.req_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 64'(bus.vfu_valid_o), 64'(1));
      chk("bp_stable", 64'(bus.issue_req_o), 64'(saved));
      chk("bp_ready", 64'(last_acc), 64'(0));
    end
    bus.vfu_ready_i = 1'b1;
    tick();
    chk("bp_release", 64'(last_acc), 64'(1));
    drain();

    // Random traffic with small register range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      bus.con_ready_i = ($urandom_range(0, 3) != 0);
      bus.lsu_ready_i = ($urandom_range(0, 3) != 0);
      bus.sld_ready_i = ($urandom_range(0, 3) != 0);
      bus.vfu_ready_i = ($urandom_range(0, 3) != 0);
      if (!bus.req_valid_i && $urandom_range(0, 2) == 0) begin
        uu = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
        bus.req_i = mk(ex_unit_e'(uu[1:0]), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom));
        bus.req_valid_i = 1'b1;
      end
      for (int u = 0; u < 4; u++) begin
        if ($urandom_range(0, 3) == 0) begin
          q.delete();
          for (int i = 0; i < 16; i++)
            if (m_busy[i] && int'(m_req[i].ex_unit) == u && !(m_out_v && m_out.id == i))
              q.push_back(i);
          if (q.size() > 0) begin
            bus.done_valid_i[u] = 1'b1;
            bus.done_id_i[u] = instr_id_t'(q[$urandom_range(0, q.size() - 1)]);
          end else begin
            pick = int'($urandom_range(0, 15));
            if (!m_busy[pick]) begin
              bus.done_valid_i[u] = 1'b1;
              bus.done_id_i[u] = instr_id_t'(pick);
            end
          end
        end
      end
      tick();
      if (last_acc) bus.req_valid_i = 1'b0;
    end
    drain();

    // Reset with an op in flight; its late retire must be ignored
    bus.vfu_ready_i = 1'b0;
    put(mk(VFU, 1, 2, 3, 1, 1, 1, 0));
    bus.req_valid_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 64'(bus.req_ready_o), 64'(0));
    chk("midrst_valids", 64'({bus.vfu_valid_o, bus.sld_valid_o, bus.lsu_valid_o, bus.con_valid_o}),
        64'(0));
    chk("midrst_issue_req", 64'(bus.issue_req_o), 64'(0));
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    mreset();
    bus.vfu_ready_i = 1'b1;
    retire(3, 0);
    chk("midrst_idle", 64'(bus.idle_o), 64'(1));
    put(mk(VFU, 1, 2, 3, 1, 1, 1, 0));
    chk("midrst_realloc_id", 64'(last_id), 64'(0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
